pause_cen_ctrl: RTL and testbench
=================================

# pause_cen_ctrl

Clock-enable generator and safe-stop gate that sits directly downstream of the pause block. It consumes `pause_cpu` and produces the fractional CPU and sound clock enables. It stops them only at a CPU bus-cycle boundary, with a bounded timeout, and resumes them without losing enable phase. The cores' CPU and sound chips run from `cpu_cen` and `snd_cen` instead of raw dividers.

## Interface
Parameters:
- `CPU_NUM`, 1: CPU enable rate numerator (rate = NUM/DEN of `clk_sys`)
- `CPU_DEN`, 4: CPU enable rate denominator
- `SND_NUM`, 1: sound enable rate numerator
- `SND_DEN`, 8: sound enable rate denominator
- `AW`, 16: accumulator width; NUM < DEN < 2^(AW-1)
- `DRAIN_MAX`, 1024: max `clk_sys` cycles spent waiting for `bus_idle` before a forced stop

Ports:
- `clk_sys`  in  1  core system clock
- `reset`  in  1  synchronous, active-high
- `pause_cpu`  in  1  pause request from the pause block, active-high
- `bus_idle`  in  1  CPU is between bus cycles (e.g. 68000 AS# high), active-high
- `cpu_cen`  out  1  CPU clock enable, single-cycle pulses
- `snd_cen`  out  1  sound clock enable, single-cycle pulses
- `paused`  out  1  enables are currently frozen
- `forced`  out  1  sticky: last stop was by timeout; cleared on the next resume

## Operation
- State is a registered FSM with three states: RUN, DRAIN, PAUSED.
- RUN:
  - if `pause_cpu` & `bus_idle`, go to PAUSED
  - else if `pause_cpu`, go to DRAIN and clear the drain counter
- DRAIN:
  - if !`pause_cpu`, go to RUN (request withdrawn)
  - else if `bus_idle`, go to PAUSED with `forced`<=0
  - else if drain counter == DRAIN_MAX-1, go to PAUSED with `forced`<=1
  - else increment the drain counter
- PAUSED: if !`pause_cpu`, go to RUN and clear `forced`.
- Gate = (next state is RUN or DRAIN). Enables keep running during DRAIN so the CPU can finish its bus cycle.
- Each channel has its own fractional accumulator. When the gate is set:
  - if acc+NUM >= DEN: acc <= acc+NUM-DEN and hit<=1
  - else: acc <= acc+NUM and hit<=0
- When the gate is clear, acc holds and hit<=0. Phase is preserved across a pause.
- `cpu_cen`/`snd_cen` are the registered hit bits. `paused` = (state==PAUSED), registered.
- Arithmetic is unsigned at AW+1 bits for the compare, so there is no overflow.
- `reset` has priority over everything:
  - state<=RUN, acc<=0, hit<=0, drain counter<=0, `forced`<=0
  - all outputs are 0 in the cycle after `reset` is sampled
- Reset mid-DRAIN or mid-PAUSED returns the block to RUN. The pause block already drops `pause_cpu` during reset.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- `pause_cpu` and `bus_idle` both high at edge t: `paused`=1 and `cpu_cen`=`snd_cen`=0 from t+1.
- `pause_cpu` high at t, `bus_idle` first high at t+k: enables continue through t+k. They are 0 and `paused`=1 from t+k+1.
- Timeout: `pause_cpu` high at t with `bus_idle` never high gives `paused`=1 and `forced`=1 at t+DRAIN_MAX+1.
- Resume: `pause_cpu` low at edge t in PAUSED gives `paused`=0 at t+1. The first enable pulse continues the saved phase, so the pulse count is identical to an unpaused run minus the frozen cycles.
- Pause and resume in the same DRAIN cycle cannot occur. A drop of `pause_cpu` always wins in DRAIN.
- Steady state: exactly NUM pulses per DEN cycles, no two consecutive pulses when NUM*2 <= DEN.

## Structure
- Package `pause_pkg`: state enum (RUN=0, DRAIN=1, PAUSED=2, 2-bit) and the localparam for the drain counter width, $clog2(DRAIN_MAX).
- One sub-module, `frac_cen` (parameters NUM, DEN, AW; ports `clk_sys`, `reset`, `gate`, `cen`), instantiated twice. The FSM, drain counter and `forced` logic stay in the top.

## Test plan
- Free-run with CPU 1/4 and SND 1/8, 800 cycles after reset: exactly 200 `cpu_cen` and 100 `snd_cen` pulses; all outputs 0 on the first cycle after reset.
- `pause_cpu` rises with `bus_idle`=0; `bus_idle` rises 5 cycles later: enables still toggle for those 5 cycles; `paused`=1 and `forced`=0 on the 6th.
- `bus_idle` held 0 with DRAIN_MAX=16: `paused`=1 and `forced`=1 exactly 17 cycles after `pause_cpu` rises. `forced` clears on the cycle after release.
- Pause for 100 cycles at accumulator phase 3 of 4, then release: the first `cpu_cen` arrives 2 cycles after `paused` falls, matching the pre-pause phase.
- `pause_cpu` pulses high for 2 cycles with `bus_idle`=0: DRAIN is entered and left, `paused` never asserts, and the pulse count equals a free run.
- `reset` asserted while PAUSED: state is RUN, `paused`=0, accumulators are 0, and the first `cpu_cen` arrives 4 cycles after `reset` falls.

Source files
------------

// File: rtl/pause_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pause_pkg
// Description : Shared types and constants for the pause-aware clock-enable
//               controller: FSM state encoding and drain counter sizing.
// Revision    : 1.0 - initial release
// ============================================================================
package pause_pkg;

    // Controller states. RUN and DRAIN both let the enables run; PAUSED
    // freezes them.
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        PAUSED = 2'd2
    } state_t;

    // Default drain budget and the matching counter width.
    localparam int c_DRAIN_MAX_DEF = 1024;
    localparam int c_DRAIN_CNT_W   = $clog2(c_DRAIN_MAX_DEF);

    // Drain counter width for an arbitrary budget. The counter only needs
    // to reach DRAIN_MAX-1; at least one bit is kept so tiny budgets still
    // produce a legal vector.
    function automatic int drain_cnt_w(input int max_cycles);
        return (max_cycles > 1) ? $clog2(max_cycles) : 1;
    endfunction

endpackage : pause_pkg
`default_nettype wire

// File: rtl/frac_cen.sv
`default_nettype none
// ============================================================================
// Module      : frac_cen
// Description : Fractional clock-enable generator. Emits NUM single-cycle
//               pulses every DEN gated cycles using a phase accumulator.
//               While the gate is low the accumulator holds, so the pulse
//               phase survives a pause.
// Ports       : clk_sys - system clock
//               reset   - synchronous active-high reset
//               gate    - advance the accumulator this cycle
//               cen     - registered enable pulse
// Revision    : 1.0 - initial release
// ============================================================================
module frac_cen #(
    parameter int NUM = 1,
    parameter int DEN = 4,
    parameter int AW  = 16
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic gate,
    output logic cen
);

    // Compare is done one bit wider than the accumulator so acc+NUM never
    // wraps before it is tested against DEN.
    localparam logic [AW:0]   c_NUM_W  = (AW+1)'(NUM);
    localparam logic [AW:0]   c_DEN_W  = (AW+1)'(DEN);
    localparam logic [AW-1:0] c_DEN_AW = AW'(DEN);

    logic [AW-1:0] r_acc;
    logic          r_hit;
    logic [AW:0]   w_sum;
    logic          w_wrap;
    logic [AW-1:0] w_acc_wrap;

    always_comb begin
        w_sum      = {1'b0, r_acc} + c_NUM_W;
        w_wrap     = (w_sum >= c_DEN_W);
        // The wrapped result is always < DEN < 2^(AW-1), so modular AW-bit
        // subtraction gives the exact value.
        w_acc_wrap = w_sum[AW-1:0] - c_DEN_AW;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_acc <= '0;
            r_hit <= 1'b0;
        end else if (gate) begin
            r_acc <= w_wrap ? w_acc_wrap : w_sum[AW-1:0];
            r_hit <= w_wrap;
        end else begin
            r_hit <= 1'b0;
        end
    end

    assign cen = r_hit;

endmodule : frac_cen
`default_nettype wire

// File: rtl/pause_cen_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pause_cen_ctrl
// Description : CPU and sound clock-enable generator with a safe-stop gate.
//               A pause request stops the enables only once the CPU sits
//               between bus cycles, or after DRAIN_MAX cycles of waiting,
//               and resumes them without losing enable phase.
// Ports       : clk_sys   - core system clock
//               reset     - synchronous active-high reset
//               pause_cpu - pause request
//               bus_idle  - CPU is between bus cycles
//               cpu_cen   - CPU clock enable pulse
//               snd_cen   - sound clock enable pulse
//               paused    - enables are frozen
//               forced    - last stop was due to drain timeout (sticky)
// Revision    : 1.0 - initial release
// ============================================================================
module pause_cen_ctrl
    import pause_pkg::*;
#(
    parameter int CPU_NUM   = 1,
    parameter int CPU_DEN   = 4,
    parameter int SND_NUM   = 1,
    parameter int SND_DEN   = 8,
    parameter int AW        = 16,
    parameter int DRAIN_MAX = 1024
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic pause_cpu,
    input  logic bus_idle,
    output logic cpu_cen,
    output logic snd_cen,
    output logic paused,
    output logic forced
);

    localparam int                  c_DRAIN_W    = drain_cnt_w(DRAIN_MAX);
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_LAST = c_DRAIN_W'(DRAIN_MAX - 1);

    state_t                 r_state;
    state_t                 w_next;
    logic [c_DRAIN_W-1:0]   r_drain_cnt;
    logic                   r_forced;
    logic                   r_paused;

    logic                   w_drain_done;
    logic                   w_gate;
    logic                   w_cnt_clr;
    logic                   w_cnt_inc;
    logic                   w_forced_nxt;

    assign w_drain_done = (r_drain_cnt == c_DRAIN_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. In DRAIN a withdrawn request is checked first so
    // a release always wins over a simultaneous stop condition.
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            RUN: begin
                if (pause_cpu && bus_idle) begin
                    w_next = PAUSED;
                end else if (pause_cpu) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!pause_cpu) begin
                    w_next = RUN;
                end else if (bus_idle || w_drain_done) begin
                    w_next = PAUSED;
                end
            end
            PAUSED: begin
                if (!pause_cpu) begin
                    w_next = RUN;
                end
            end
            default: w_next = RUN;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / control decode. The gate looks at the next state so the
    // enables stop on the same edge that enters PAUSED.
    // ------------------------------------------------------------------
    always_comb begin
        w_gate       = (w_next == RUN) || (w_next == DRAIN);
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_forced_nxt = r_forced;
        case (r_state)
            RUN: begin
                if (w_next == DRAIN) begin
                    w_cnt_clr = 1'b1;
                end else if (w_next == PAUSED) begin
                    w_forced_nxt = 1'b0;
                end
            end
            DRAIN: begin
                if (w_next == DRAIN) begin
                    w_cnt_inc = 1'b1;
                end else if (w_next == PAUSED) begin
                    // Only a stop without bus_idle is a timeout stop.
                    w_forced_nxt = !bus_idle;
                end
            end
            PAUSED: begin
                if (w_next == RUN) begin
                    w_forced_nxt = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Drain counter, sticky forced flag and registered paused flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_drain_cnt <= '0;
            r_forced    <= 1'b0;
            r_paused    <= 1'b0;
        end else begin
            if (w_cnt_clr) begin
                r_drain_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_drain_cnt <= r_drain_cnt + 1'b1;
            end
            r_forced <= w_forced_nxt;
            r_paused <= (w_next == PAUSED);
        end
    end

    // ------------------------------------------------------------------
    // Enable generators
    // ------------------------------------------------------------------
    frac_cen #(
        .NUM (CPU_NUM),
        .DEN (CPU_DEN),
        .AW  (AW)
    ) u_cpu_cen (
        .clk_sys (clk_sys),
        .reset   (reset),
        .gate    (w_gate),
        .cen     (cpu_cen)
    );

    frac_cen #(
        .NUM (SND_NUM),
        .DEN (SND_DEN),
        .AW  (AW)
    ) u_snd_cen (
        .clk_sys (clk_sys),
        .reset   (reset),
        .gate    (w_gate),
        .cen     (snd_cen)
    );

    assign paused = r_paused;
    assign forced = r_forced;

endmodule : pause_cen_ctrl
`default_nettype wire

// File: tb/tb_pause_cen_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pause_cen_ctrl
// Description : Directed self-checking bench for pause_cen_ctrl with
//               CPU 1/4, SND 1/8 and a 16-cycle drain budget.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pause_cen_ctrl;

    logic clk_sys = 1'b0;
    logic reset;
    logic pause_cpu;
    logic bus_idle;
    logic cpu_cen;
    logic snd_cen;
    logic paused;
    logic forced;

    int n_checks   = 0;
    int n_fail     = 0;
    int cpu_cnt    = 0;
    int snd_cnt    = 0;
    int paused_cnt = 0;

    always #5 clk_sys = ~clk_sys;

    pause_cen_ctrl #(
        .CPU_NUM   (1),
        .CPU_DEN   (4),
        .SND_NUM   (1),
        .SND_DEN   (8),
        .AW        (16),
        .DRAIN_MAX (16)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .pause_cpu (pause_cpu),
        .bus_idle  (bus_idle),
        .cpu_cen   (cpu_cen),
        .snd_cen   (snd_cen),
        .paused    (paused),
        .forced    (forced)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive inputs, let one rising edge sample them, then observe the
    // outputs 1 ns later and accumulate pulse counts.
    task automatic step(input logic rst, input logic p, input logic bi);
        reset     = rst;
        pause_cpu = p;
        bus_idle  = bi;
        @(posedge clk_sys);
        #1;
        cpu_cnt    = cpu_cnt + int'(cpu_cen);
        snd_cnt    = snd_cnt + int'(snd_cen);
        paused_cnt = paused_cnt + int'(paused);
    endtask

    task automatic clr_cnt();
        cpu_cnt    = 0;
        snd_cnt    = 0;
        paused_cnt = 0;
    endtask

    initial begin
        reset     = 1'b1;
        pause_cpu = 1'b0;
        bus_idle  = 1'b0;

        // Reset state
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk_eq("rst_cpu_cen", 32'(cpu_cen), 32'd0);
        chk_eq("rst_snd_cen", 32'(snd_cen), 32'd0);
        chk_eq("rst_paused",  32'(paused),  32'd0);
        chk_eq("rst_forced",  32'(forced),  32'd0);

        // Free run: 800 cycles -> 200 CPU, 100 sound pulses; first CPU
        // pulse on the 4th edge after reset falls.
        clr_cnt();
        for (int i = 1; i <= 800; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (i <= 4) chk_eq($sformatf("free_cpu_first_%0d", i), 32'(cpu_cen), 32'(i == 4));
        end
        chk_eq("free_cpu_count", 32'(cpu_cnt), 32'd200);
        chk_eq("free_snd_count", 32'(snd_cnt), 32'd100);
        chk_eq("free_paused",    32'(paused_cnt), 32'd0);

        // Drain, bus_idle arrives 5 cycles late. Accumulators start at 0:
        // 5 gated edges give one CPU pulse and no sound pulse.
        clr_cnt();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
        chk_eq("drain_cpu_count", 32'(cpu_cnt), 32'd1);
        chk_eq("drain_snd_count", 32'(snd_cnt), 32'd0);
        chk_eq("drain_not_paused", 32'(paused_cnt), 32'd0);
        step(1'b0, 1'b1, 1'b1);
        chk_eq("drain_paused",  32'(paused),  32'd1);
        chk_eq("drain_forced",  32'(forced),  32'd0);
        chk_eq("drain_cpu_off", 32'(cpu_cen), 32'd0);

        // Hold paused for 100 cycles total; CPU phase is 1 of 4 (three
        // gated edges to the next pulse), sound phase 5 of 8.
        clr_cnt();
        for (int i = 0; i < 99; i++) step(1'b0, 1'b1, 1'b1);
        chk_eq("hold_cpu_count", 32'(cpu_cnt), 32'd0);
        chk_eq("hold_snd_count", 32'(snd_cnt), 32'd0);
        chk_eq("hold_paused",    32'(paused_cnt), 32'd99);

        // Release: paused falls at once, both enables fire 2 cycles later.
        step(1'b0, 1'b0, 1'b0);
        chk_eq("rel_paused", 32'(paused),  32'd0);
        chk_eq("rel_cpu_0",  32'(cpu_cen), 32'd0);
        step(1'b0, 1'b0, 1'b0);
        chk_eq("rel_cpu_1",  32'(cpu_cen), 32'd0);
        chk_eq("rel_snd_1",  32'(snd_cen), 32'd0);
        step(1'b0, 1'b0, 1'b0);
        chk_eq("rel_cpu_2",  32'(cpu_cen), 32'd1);
        chk_eq("rel_snd_2",  32'(snd_cen), 32'd1);

        // Timeout: bus_idle never rises, stop on the 17th observation.
        clr_cnt();
        for (int i = 1; i <= 17; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (i == 16) begin
                chk_eq("tmo_paused_16", 32'(paused), 32'd0);
                chk_eq("tmo_forced_16", 32'(forced), 32'd0);
            end
            if (i == 17) begin
                chk_eq("tmo_paused_17", 32'(paused),  32'd1);
                chk_eq("tmo_forced_17", 32'(forced),  32'd1);
                chk_eq("tmo_cpu_17",    32'(cpu_cen), 32'd0);
            end
        end
        chk_eq("tmo_cpu_count", 32'(cpu_cnt), 32'd4);
        chk_eq("tmo_snd_count", 32'(snd_cnt), 32'd2);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        chk_eq("tmo_forced_sticky", 32'(forced), 32'd1);
        step(1'b0, 1'b0, 1'b0);
        chk_eq("tmo_forced_clr", 32'(forced), 32'd0);
        chk_eq("tmo_paused_clr", 32'(paused), 32'd0);

        // Short 2-cycle request: DRAIN entered and left, no pause, and a
        // 64-cycle window yields exactly the free-run pulse count.
        clr_cnt();
        for (int i = 1; i <= 64; i++) step(1'b0, (i <= 2), 1'b0);
        chk_eq("blip_paused",    32'(paused_cnt), 32'd0);
        chk_eq("blip_cpu_count", 32'(cpu_cnt), 32'd16);
        chk_eq("blip_snd_count", 32'(snd_cnt), 32'd8);
        chk_eq("blip_forced",    32'(forced), 32'd0);

        // Immediate stop, then reset while PAUSED.
        step(1'b0, 1'b1, 1'b1);
        chk_eq("imm_paused", 32'(paused),  32'd1);
        chk_eq("imm_cpu",    32'(cpu_cen), 32'd0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        chk_eq("prst_paused", 32'(paused),  32'd0);
        chk_eq("prst_forced", 32'(forced),  32'd0);
        chk_eq("prst_cpu",    32'(cpu_cen), 32'd0);
        chk_eq("prst_snd",    32'(snd_cen), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (i <= 4) chk_eq($sformatf("prst_cpu_%0d", i), 32'(cpu_cen), 32'(i == 4));
            chk_eq($sformatf("prst_snd_%0d", i), 32'(snd_cen), 32'(i == 8));
            chk_eq($sformatf("prst_paused_%0d", i), 32'(paused), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pause_cen_ctrl
`default_nettype wire
